faims_hv_regulator: RTL and testbench

- Closed-loop HV regulator on the FPGA, directly upstream of the faims pulse/coil driver.
- Accepts HV feedback ADC samples through a valid/ready handshake and compares them against a soft-started setpoint.
- Runs a shift-based PI loop and produces the faims work parameter (o_parWork, feeds i_parWork).
- Owns HV overvoltage shutdown.

---
 rtl/faims_pkg.sv | 35 +++
 rtl/faims_hv_softstart.sv | 42 ++++
 rtl/faims_hv_regulator.sv | 147 ++++++++++++++
 tb/tb_faims_hv_regulator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/faims_pkg.sv
// Shared definitions for the FAIMS HV regulator: state encoding, default widths
// and the work-value clamp used by the PI output stage.
package faims_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RAMP     = 2'd1;
  localparam logic [1:0] ST_REGULATE = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  localparam int WORK_W_DEF = 8;

  typedef struct packed {
    logic [31:0] value;
    logic        high;
    logic        low;
  } clampResult_t;

  // Clamp a signed value into [0, upper] and report which side clipped.
  function automatic clampResult_t clampWork(input logic signed [31:0] value,
                                             input logic signed [31:0] upper);
    clampResult_t r;
    r.value = value;
    r.high  = 1'b0;
    r.low   = 1'b0;
    if (value < 0) begin
      r.value = '0;
      r.low   = 1'b1;
    end else if (value > upper) begin
      r.value = upper;
      r.high  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/faims_hv_softstart.sv
// Soft-start target generator: ramps up one LSB per SOFT_STEP_DIV clocks and
// follows a lower setpoint immediately.
module faims_hv_softstart #(
  parameter int ADC_W         = 12,
  parameter int SOFT_STEP_DIV = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] setpoint,
  output logic [ADC_W-1:0] target,
  output logic             at_setpoint
);

  localparam int PW = (SOFT_STEP_DIV > 1) ? $clog2(SOFT_STEP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SOFT_STEP_DIV - 1);

  logic [PW-1:0] prescale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target   <= '0;
      prescale <= '0;
    end else if (!enable) begin
      target   <= '0;
      prescale <= '0;
    end else if (setpoint < target) begin
      target   <= setpoint;
      prescale <= '0;
    end else if (setpoint == target) begin
      prescale <= '0;
    end else if (prescale == PRE_LAST) begin
      target   <= target + ADC_W'(1);
      prescale <= '0;
    end else begin
      prescale <= prescale + PW'(1);
    end
  end

  assign at_setpoint = (target == setpoint);

endmodule

// File: rtl/faims_hv_regulator.sv
// Closed-loop HV regulator: soft-started target, 3-stage shift-based PI loop,
// overvoltage shutdown. Define FAIMS_HV_SAMPLE_AVG_EN to average 4 samples per update.
module faims_hv_regulator import faims_pkg::*; #(
  parameter int ADC_W         = 12,
  parameter int WORK_W        = WORK_W_DEF,
  parameter int ACC_W         = 20,
  parameter int KP_SHIFT      = 2,
  parameter int KI_SHIFT      = 5,
  parameter int SOFT_STEP_DIV = 256,
  parameter int OV_LIMIT      = 4000
) (
  input  logic              CLK,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [ADC_W-1:0]  i_setpoint,
  input  logic [WORK_W-1:0] i_workMax,
  input  logic [ADC_W-1:0]  i_sample,
  input  logic              i_sample_valid,
  output logic              o_sample_ready,
  output logic [WORK_W-1:0] o_parWork,
  output logic              o_work_valid,
  output logic              o_saturated,
  output logic              o_overvolt,
  output logic [1:0]        o_state
);

  // Handshake: a sample transfers on a rising CLK edge where i_sample_valid and
  // o_sample_ready are both high; ready is low while a sample is in c1 or c2.
  localparam logic signed [ACC_W:0] ACC_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] ACC_MIN = $signed({2'b11, {(ACC_W-1){1'b0}}});

  logic [1:0]               state;
  logic [ADC_W-1:0]         target;
  logic                     atSetpoint;
  logic                     runActive, accept, ovHit;
  logic                     feedValid;
  logic [ADC_W-1:0]         feedSample;
  logic                     s1Valid, s2Valid;
  logic [ADC_W-1:0]         s1Sample;
  logic signed [ADC_W:0]    s2Err, errP;
  logic signed [ACC_W-1:0]  integ, integNext, integI;
  logic signed [ACC_W:0]    integSum, pSum;
  clampResult_t             clampRes;
  logic                     holdInteg;

  assign runActive      = (state == ST_RAMP) || (state == ST_REGULATE);
  assign o_sample_ready = !(s1Valid || s2Valid);
  assign accept         = i_sample_valid && o_sample_ready;
  assign ovHit          = accept && runActive && (i_sample >= ADC_W'(OV_LIMIT));
  assign o_state        = state;

  faims_hv_softstart #(.ADC_W(ADC_W), .SOFT_STEP_DIV(SOFT_STEP_DIV)) u_softstart (
    .clk(CLK), .rst_n(i_reset_n), .enable(runActive), .setpoint(i_setpoint),
    .target(target), .at_setpoint(atSetpoint)
  );

`ifdef FAIMS_HV_SAMPLE_AVG_EN
  logic [ADC_W+1:0] avgAcc, avgSum;
  logic [1:0]       avgCnt;

  assign avgSum     = avgAcc + (ADC_W+2)'(i_sample);
  assign feedValid  = accept && runActive && (avgCnt == 2'd3);
  assign feedSample = avgSum[ADC_W+1:2];

  always_ff @(posedge CLK or negedge i_reset_n) begin
    if (!i_reset_n) begin
      avgAcc <= '0;
      avgCnt <= '0;
    end else if (!runActive) begin
      avgAcc <= '0;
      avgCnt <= '0;
    end else if (accept) begin
      avgAcc <= (avgCnt == 2'd3) ? '0 : avgSum;
      avgCnt <= avgCnt + 2'd1;
    end
  end
`else
  assign feedValid  = accept && runActive;
  assign feedSample = i_sample;
`endif

  // c2: saturating integrator, PI sum, output clamp, anti-windup decision.
  always_comb begin
    integSum = (ACC_W+1)'(integ) + (ACC_W+1)'(s2Err);
    if (integSum > ACC_MAX)      integNext = ACC_MAX[ACC_W-1:0];
    else if (integSum < ACC_MIN) integNext = ACC_MIN[ACC_W-1:0];
    else                         integNext = integSum[ACC_W-1:0];
    errP      = s2Err >>> KP_SHIFT;
    integI    = integNext >>> KI_SHIFT;
    pSum      = (ACC_W+1)'(errP) + (ACC_W+1)'(integI);
    clampRes  = clampWork(32'(pSum), $signed(32'(i_workMax)));
    holdInteg = (clampRes.high && !s2Err[ADC_W] && (s2Err != '0)) ||
                (clampRes.low && s2Err[ADC_W]);
  end

  always_ff @(posedge CLK or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ST_IDLE;
      o_parWork    <= '0;
      o_work_valid <= 1'b0;
      o_saturated  <= 1'b0;
      o_overvolt   <= 1'b0;
      s1Valid      <= 1'b0;
      s2Valid      <= 1'b0;
      s1Sample     <= '0;
      s2Err        <= '0;
      integ        <= '0;
    end else if (ovHit) begin
      state        <= ST_FAULT;
      o_parWork    <= '0;
      o_work_valid <= 1'b1;
      o_saturated  <= 1'b0;
      o_overvolt   <= 1'b1;
      s1Valid      <= 1'b0;
      s2Valid      <= 1'b0;
      integ        <= '0;
    end else if (!i_enable && (state != ST_IDLE)) begin
      state        <= ST_IDLE;
      o_parWork    <= '0;
      o_work_valid <= 1'b1;
      o_saturated  <= 1'b0;
      o_overvolt   <= 1'b0;
      s1Valid      <= 1'b0;
      s2Valid      <= 1'b0;
      integ        <= '0;
    end else begin
      o_work_valid <= 1'b0;
      case (state)
        ST_IDLE:     if (i_enable) state <= ST_RAMP;
        ST_RAMP:     if (atSetpoint) state <= ST_REGULATE;
        ST_REGULATE: if (i_setpoint > target) state <= ST_RAMP;
        default:     state <= ST_FAULT;
      endcase
      s1Valid <= feedValid;
      if (feedValid) s1Sample <= feedSample;
      s2Valid <= s1Valid;
      if (s1Valid) s2Err <= $signed({1'b0, target}) - $signed({1'b0, s1Sample});
      if (s2Valid) begin
        o_parWork    <= WORK_W'(clampRes.value);
        o_work_valid <= 1'b1;
        o_saturated  <= clampRes.high || clampRes.low;
        if (!holdInteg) integ <= integNext;
      end
    end
  end

endmodule

// File: tb/tb_faims_hv_regulator.sv
// Directed bench for faims_hv_regulator: expected work updates go into a queue
// at issue time and a negedge monitor pops them on every o_work_valid pulse.
module tb_faims_hv_regulator;

  localparam int ADC_W  = 12;
  localparam int WORK_W = 8;
`ifdef FAIMS_HV_SAMPLE_AVG_EN
  localparam int GROUP = 4;
`else
  localparam int GROUP = 1;
`endif

  logic              CLK = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_enable = 1'b0;
  logic [ADC_W-1:0]  i_setpoint = '0;
  logic [WORK_W-1:0] i_workMax = 8'd255;
  logic [ADC_W-1:0]  i_sample = '0;
  logic              i_sample_valid = 1'b0;
  logic              o_sample_ready;
  logic [WORK_W-1:0] o_parWork;
  logic              o_work_valid;
  logic              o_saturated;
  logic              o_overvolt;
  logic [1:0]        o_state;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];  // {overvolt, saturated, parWork}

  faims_hv_regulator #(.SOFT_STEP_DIV(1)) dut (
    .CLK(CLK), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_setpoint(i_setpoint),
    .i_workMax(i_workMax), .i_sample(i_sample), .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready), .o_parWork(o_parWork), .o_work_valid(o_work_valid),
    .o_saturated(o_saturated), .o_overvolt(o_overvolt), .o_state(o_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] ev(input logic ov, input logic sat, input int par);
    return {ov, sat, 8'(par)};
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    logic [9:0] got, exp;
    if (i_reset_n && o_work_valid) begin
      got = {o_overvolt, o_saturated, o_parWork};
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_update: got par=%0d sat=%0d ov=%0d expected no update",
                 o_parWork, o_saturated, o_overvolt);
      end else begin
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL work_update: got par=%0d sat=%0d ov=%0d expected par=%0d sat=%0d ov=%0d",
                   got[7:0], got[8], got[9], exp[7:0], exp[8], exp[9]);
        end
      end
    end
  end

  // driver tasks
  task automatic send_raw(input int value);
    int guard;
    guard = 0;
    @(negedge CLK);
    while (!o_sample_ready && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check("sample_ready_wait", o_sample_ready, 1);
    i_sample       = ADC_W'(value);
    i_sample_valid = 1'b1;
    @(posedge CLK);
    #1;
    i_sample_valid = 1'b0;
  endtask

  task automatic send_update(input int value, input logic [9:0] expected);
    exp_q.push_back(expected);
    for (int k = 0; k < GROUP; k++) send_raw(value);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, output int cycles);
    cycles = 0;
    while (o_state != st && cycles < budget) begin
      @(negedge CLK);
      cycles++;
    end
    check("wait_state", o_state, st);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending updates expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic disable_run();
    exp_q.push_back(ev(1'b0, 1'b0, 0));
    @(negedge CLK);
    i_enable = 1'b0;
    @(negedge CLK);
    check("disable_state", o_state, 0);
    check("disable_overvolt", o_overvolt, 0);
    drain();
  endtask

  task automatic enable_to_regulate();
    int cycles;
    @(negedge CLK);
    i_enable = 1'b1;
    wait_state(2'd2, 1200, cycles);
    // one clock IDLE->RAMP, 1000 single-clock steps, one clock to see the match
    check("ramp_cycles", cycles, 1002);
  endtask

  initial begin
    int cycles, lat;
    // reset state
    repeat (3) begin
      @(negedge CLK);
      check("reset_state", o_state, 0);
      check("reset_ready", o_sample_ready, 1);
      check("reset_work_valid", o_work_valid, 0);
    end
    i_reset_n = 1'b1;

    // reset mid-RAMP
    i_setpoint = 12'd1000;
    @(negedge CLK);
    i_enable = 1'b1;
    repeat (20) @(negedge CLK);
    check("ramp_state", o_state, 1);
    i_reset_n = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("midramp_reset_state", o_state, 0);
      check("midramp_reset_parwork", o_parWork, 0);
      check("midramp_reset_ready", o_sample_ready, 1);
    end
    i_enable  = 1'b0;
    i_reset_n = 1'b1;
    repeat (2) @(negedge CLK);

    // ramp to 1000, zero error, then err 100 -> 25 + 3
    enable_to_regulate();
    send_update(1000, ev(1'b0, 1'b0, 0));
    drain();
    send_update(900, ev(1'b0, 1'b0, 28));
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (lat == 1) check("ready_low_c1", o_sample_ready, 0);
    end while (!o_work_valid && lat < 10);
    check("work_latency", lat, 3);
    drain();
    disable_run();

    // clamp high with anti-windup: integrator must stay at 0 across clamped updates
    i_workMax = 8'd20;
    enable_to_regulate();
    send_update(900, ev(1'b0, 1'b1, 20));
    send_update(900, ev(1'b0, 1'b1, 20));
    drain();
    i_workMax = 8'd255;
    send_update(900, ev(1'b0, 1'b0, 28));
    drain();

    // setpoint drop follows at once (integ 100 -> 3 at zero error), rise ramps
    @(negedge CLK);
    i_setpoint = 12'd500;
    @(negedge CLK);
    check("drop_state", o_state, 2);
    send_update(500, ev(1'b0, 1'b0, 3));
    drain();
    @(negedge CLK);
    i_setpoint = 12'd600;
    @(negedge CLK);
    check("rise_state", o_state, 1);
    wait_state(2'd2, 200, cycles);
    check("rise_cycles", cycles, 100);

    // overvoltage
    exp_q.push_back(ev(1'b1, 1'b0, 0));
    send_raw(4000);
    @(negedge CLK);
    check("ov_state", o_state, 3);
    check("ov_parwork", o_parWork, 0);
    check("ov_flag", o_overvolt, 1);
    drain();
    check("fault_hold", o_state, 3);
    disable_run();

    // clamp low with anti-windup: err -100 must not wind the integrator negative
    i_setpoint = 12'd1000;
    enable_to_regulate();
    send_update(1100, ev(1'b0, 1'b1, 0));
    send_update(1000, ev(1'b0, 1'b0, 0));
    drain();

`ifdef FAIMS_HV_SAMPLE_AVG_EN
    // mean of 896,900,904,900 is 900 -> single update of 28
    exp_q.push_back(ev(1'b0, 1'b0, 28));
    send_raw(896);
    send_raw(900);
    send_raw(904);
    send_raw(900);
    drain();
`endif

    disable_run();
    repeat (5) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
